// File: rtl/dot3_pkg.sv
// rtl/dot3_pkg.sv - shared state encoding and widths for the 3-bit dot product block
package dot3_pkg;

  localparam int ACC_W   = 10;
  localparam int LEN_MAX = 16;
  localparam int PROD_W  = 6;
  localparam int CNT_W   = 5;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [ACC_W-1:0] widen_product(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/multiplier_3bit.sv
// rtl/multiplier_3bit.sv - combinational 3x3 unsigned multiplier
module multiplier_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] product
);

  assign product = {3'b000, a} * {3'b000, b};

endmodule

// File: rtl/dot_product_3bit.sv
// rtl/dot_product_3bit.sv - accumulates LEN products a*b and hands the sum off with a valid/ready pair
module dot_product_3bit
  import dot3_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       a,
  input  logic [2:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] next_acc;
  logic [CNT_W-1:0] cnt;
  logic [PROD_W-1:0] product;

  multiplier_3bit u_mult (
    .a       (a),
    .b       (b),
    .product (product)
  );

  assign next_acc  = acc + widen_product(product);
  // Handshake flags decode straight from the state register, so in_valid never reaches in_ready.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign busy      = (cnt != '0) || (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              // Accumulator and counter clear on entry to HOLD so ACC restarts from zero.
              out_sum <= next_acc;
              acc     <= '0;
              cnt     <= '0;
              state   <= HOLD;
            end else begin
              acc <= next_acc;
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_sum <= '0;
            state   <= ACC;
          end
        end
        default: begin
          state   <= ACC;
          acc     <= '0;
          cnt     <= '0;
          out_sum <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/dot_product_3bit.md
DOT_PRODUCT_3BIT -- requirements
Module: dot_product_3bit

Interface
REQ-001 SHALL have parameter: LEN, 4, products per dot product; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: clr  input  1  synchronous abort of the current accumulation or held result.
REQ-005 SHALL have port: in_valid  input  1  operand pair present.
REQ-006 SHALL have port: in_ready  output  1  block accepts a pair this cycle.
REQ-007 SHALL have port: a  input  3  unsigned multiplicand.
REQ-008 SHALL have port: b  input  3  unsigned multiplier.
REQ-009 SHALL have port: out_valid  output  1  out_sum holds a completed dot product.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: out_sum  output  10  unsigned sum of LEN products.
REQ-012 SHALL have port: busy  output  1  at least one pair accepted and the result not yet delivered.

Function
REQ-013 SHALL define pair acceptance as in_valid=1 and in_ready=1 on a rising edge.
REQ-014 SHALL implement the FSM states ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL, on each accepted pair in ACC, add the 6-bit product a*b, zero-extended to 10 bits, to the accumulator and increment a 5-bit pair counter.
REQ-016 SHALL, when the LEN-th pair is accepted, register acc+a*b into out_sum and enter HOLD, so out_valid rises exactly one cycle after the last acceptance.
REQ-017 SHALL hold out_sum and out_valid stable in HOLD until out_ready=1, and ignore in_valid while in HOLD.
REQ-018 SHALL, on out_valid=1 and out_ready=1, return to ACC next cycle with accumulator and counter at 0; no pair is accepted in that same cycle.
REQ-019 SHALL drive out_sum to 0 whenever the FSM is in ACC.
REQ-020 SHALL never overflow the accumulator: 16*49 = 784 < 1024; no saturation logic.
REQ-021 SHALL treat clr=1 as dominant: next state ACC, accumulator, counter and out_sum set to 0, and any pair presented in the same cycle discarded.
REQ-022 SHALL let clr=1 in HOLD drop the result without an out_valid/out_ready handshake.
REQ-023 SHALL drive busy = (counter != 0) or HOLD.
REQ-024 SHALL, with LEN=1, enter HOLD after every accepted pair, producing out_sum = a*b.
REQ-025 SHALL keep in_ready independent of in_valid, with no combinational path from in_valid to in_ready.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, set state ACC, accumulator 0, counter 0, out_sum 0, out_valid 0, in_ready 1, busy 0.
REQ-027 SHALL give rst priority over clr and all handshakes, including mid-accumulation and in HOLD.

Structure
REQ-028 SHALL place the FSM state encoding (ACC, HOLD), ACC_W=10 and LEN_MAX=16 in the shared package dot3_pkg.
REQ-029 SHALL form the product by instantiating the existing combinational multiplier_3bit (a, b -> 6-bit product) as its single sub-module, with no registers inside it.

Verification
REQ-030 SHALL cover: LEN=4, pairs (3,5) x4 back-to-back, out_ready=1 -> out_valid one cycle after the 4th pair, out_sum=60.
REQ-031 SHALL cover: LEN=16, (7,7) x16 -> out_sum=784, no wrap; then (0,7) x16 -> out_sum=0.
REQ-032 SHALL cover: LEN=4, pairs (1,1),(2,3),(7,0),(5,6), out_ready=0 for 5 cycles -> out_sum=37 held stable and in_ready=0 throughout; release -> ACC next cycle.
REQ-033 SHALL cover: LEN=4, two pairs (7,7) accepted, then clr=1 together with in_valid=1 (a=2,b=2) -> pair dropped, busy=0; next 4 pairs (1,1) -> out_sum=4.
REQ-034 SHALL cover: rst=1 in HOLD holding out_sum=60 -> next cycle out_valid=0, out_sum=0, in_ready=1; a fresh sequence from 0 yields the correct sum.
REQ-035 SHALL cover: LEN=1, exhaustive a,b in 0..7 -> out_sum=a*b for each of the 64 pairs.
